ann_input_capture: RTL and testbench
====================================

// Module: ann_input_capture
// PURPOSE
//  Downstream of the VGA colour mapper. Captures the thresholded 1-bit pixel stream (x_values) from
//  the checkerboard-subsampled 100x160 box, strobed by RstH/Get/Get_done. Packs samples into a word
//  buffer and presents one complete frame to the ANN input layer through a valid/ack handshake and
//  a synchronous read port. Buffer is frozen while the ANN consumes it.
// PARAMETERS
//  NUM_SAMPLES  8000  samples per frame; must be a multiple of WORD_W
//  WORD_W       16    bits per buffer word
//  ADDR_W       9     word address width; 2**ADDR_W >= NUM_SAMPLES/WORD_W (500 words)
//  SKIP_FIRST   1     1 = discard first Get after RstH (lead-in strobe at X=269,Y=160)
// PORTS
//  Clk          in   1       system clock
//  RST          in   1       asynchronous reset, active-low
//  Pix_En       in   1       one-Clk pulse per VGA pixel; strobes are sampled only when high
//  RstH         in   1       frame-start strobe from colour mapper
//  Get          in   1       sample strobe from colour mapper
//  Get_done     in   1       frame-end strobe from colour mapper
//  x_values     in   1       thresholded pixel (0 = black, 1 = white)
//  Frame_Ack    in   1       ANN releases buffer (sampled only in READY)
//  Rd_Addr      in   ADDR_W  ANN word read address
//  Rd_Data      out  WORD_W  word at Rd_Addr, 1-Clk latency
//  Frame_Valid  out  1       complete frame held in buffer
//  Frame_Err    out  1       one-Clk pulse: frame ended with wrong sample count or overflow
//  Busy         out  1       high in CAPTURE
//  Sample_Cnt   out  14      accepted samples in current or last frame
// BEHAVIOUR
//  Reset (RST=0, async): state IDLE; Frame_Valid=0, Frame_Err=0, Busy=0, Sample_Cnt=0, Rd_Data=0,
//  shift reg, skip and ovf flags cleared. Buffer contents are not reset.
//  An event is strobe & Pix_En. Strobes without Pix_En are ignored. This handles multi-Clk pixel
//  periods and adjacent Gets.
//  FSM:
//   IDLE:    RstH event -> CAPTURE. Clear Sample_Cnt, shift reg, ovf. Set skip = SKIP_FIRST.
//            Get and Get_done events ignored.
//   CAPTURE: Busy=1.
//            RstH event -> restart CAPTURE with the same clears. Partial frame discarded, no Err.
//            Get event with skip=1 -> clear skip; no sample stored.
//            Get event otherwise, Sample_Cnt<NUM_SAMPLES -> x_values shifted into word; Sample_Cnt+1.
//              Sample k goes to bit (k mod WORD_W), i.e. first sample in LSB.
//              On the WORD_W-th bit, write the full word to buffer[k/WORD_W] in the same Clk.
//            Get event with Sample_Cnt==NUM_SAMPLES -> set ovf; nothing stored.
//            Get_done event -> if Sample_Cnt==NUM_SAMPLES and ovf=0: READY, Frame_Valid=1 next Clk.
//              Otherwise: Frame_Err=1 for one Clk, then IDLE.
//   READY:   Frame_Valid=1. RstH, Get and Get_done ignored; buffer writes inhibited.
//            Frame_Ack=1 -> IDLE next Clk; Frame_Valid drops in that Clk.
//            A RstH event in the same Clk as Frame_Ack is ignored; the next frame waits for the next RstH.
//  Simultaneous events in CAPTURE:
//   - RstH beats Get and Get_done.
//   - Get is processed before the Get_done check in the same Clk; the just-counted sample is included.
//  Frame_Ack outside READY has no effect.
//  Read port: Rd_Data <= buffer[Rd_Addr] every Clk in every state. Content is guaranteed only in READY.
//   Rd_Addr >= NUM_SAMPLES/WORD_W returns undefined data.
//   A read of the address being written in the same Clk returns old data.
//  Sample_Cnt saturates at NUM_SAMPLES and holds its value through READY/IDLE until the next RstH event.
// TESTING
//  1 Full frame, default params: RstH, one lead-in Get, 8000 Gets with x_values = k[0], then Get_done.
//    -> Frame_Valid=1, Sample_Cnt=8000, each read word = 16'hAAAA; Frame_Ack -> Valid=0 next Clk.
//  2 Short frame: 7999 samples then Get_done -> Frame_Err 1-Clk pulse, IDLE, Frame_Valid stays 0.
//  3 Overflow: 8001 samples then Get_done -> Frame_Err pulse. Buffer word 499 holds samples 7984-7999.
//  4 Held buffer: in READY, issue a full new frame with all x_values=0 -> ignored, reads unchanged.
//    Ack, then a new all-0 frame -> all words 16'h0000.
//  5 Mid-frame RstH: after 3000 samples, RstH then a full valid frame.
//    -> Frame_Valid, Sample_Cnt=8000, no Frame_Err.
//  6 Pix_En gating/reset: Get held 2 Clks with Pix_En on 1 -> counts 1.
//    Assert RST mid-CAPTURE -> immediately IDLE, Busy=0, Sample_Cnt=0.

Source files
------------

// File: rtl/ann_input_capture_if.sv
// ---------------------------------------------------------------------------
// ann_input_capture_if
// Bundles the colour-mapper strobes, the ANN handshake and the ANN read port
// of ann_input_capture into one interface.
//   master : the environment side (colour mapper + ANN), drives strobes,
//            x_values, Frame_Ack and Rd_Addr; observes the capture status.
//   slave  : the capture block itself.
// Signals
//   Pix_En, RstH, Get, Get_done, x_values : pixel-stream strobes and data
//   Frame_Ack, Rd_Addr                    : ANN release and word read address
//   Rd_Data, Frame_Valid, Frame_Err,
//   Busy, Sample_Cnt                      : read data and capture status
// ---------------------------------------------------------------------------
interface ann_input_capture_if #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 9
);
  logic              Pix_En;
  logic              RstH;
  logic              Get;
  logic              Get_done;
  logic              x_values;
  logic              Frame_Ack;
  logic [ADDR_W-1:0] Rd_Addr;
  logic [WORD_W-1:0] Rd_Data;
  logic              Frame_Valid;
  logic              Frame_Err;
  logic              Busy;
  logic [13:0]       Sample_Cnt;

  modport master (
    output Pix_En, RstH, Get, Get_done, x_values, Frame_Ack, Rd_Addr,
    input  Rd_Data, Frame_Valid, Frame_Err, Busy, Sample_Cnt
  );

  modport slave (
    input  Pix_En, RstH, Get, Get_done, x_values, Frame_Ack, Rd_Addr,
    output Rd_Data, Frame_Valid, Frame_Err, Busy, Sample_Cnt
  );
endinterface

// File: rtl/ann_input_capture.sv
// ---------------------------------------------------------------------------
// ann_input_capture
// Captures the thresholded 1-bit pixel stream from the VGA colour mapper,
// packs it LSB-first into WORD_W-bit words and holds one complete frame for
// the ANN input layer. The frame is offered via Frame_Valid / Frame_Ack and
// read through a synchronous (1-Clk latency) word read port. While a frame is
// held (READY) the buffer is frozen and all capture strobes are ignored.
// Ports
//   Clk  : system clock
//   RST  : asynchronous reset, active-low
//   bus  : slave side of ann_input_capture_if (strobes, handshake, read port)
// ---------------------------------------------------------------------------
module ann_input_capture #(
  parameter int NUM_SAMPLES = 8000,
  parameter int WORD_W      = 16,
  parameter int ADDR_W      = 9,
  parameter int SKIP_FIRST  = 1
) (
  input logic                 Clk,
  input logic                 RST,
  ann_input_capture_if.slave  bus
);

  localparam int          DEPTH    = 1 << ADDR_W;
  localparam int          BIT_W    = $clog2(WORD_W);
  localparam logic [13:0] NUM_C    = 14'(NUM_SAMPLES);
  localparam logic [BIT_W-1:0] LAST_BIT = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READY   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [13:0]       cnt_q, cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              skip_q, skip_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;

  logic              rsth_ev, get_ev, done_ev;

  // Frame buffer: deliberately not reset.
  logic [WORD_W-1:0] mem [0:DEPTH-1];

  // Strobes only count when they coincide with a pixel enable, so a strobe
  // held across a multi-Clk pixel period is seen once.
  assign rsth_ev = bus.RstH     & bus.Pix_En;
  assign get_ev  = bus.Get      & bus.Pix_En;
  assign done_ev = bus.Get_done & bus.Pix_En;

  // Next-state and datapath control. Within CAPTURE, RstH wins over
  // everything; a Get in the same Clk as Get_done is counted first so the
  // completion check sees the updated count and overflow flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    skip_d  = skip_q;
    ovf_d   = ovf_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = ADDR_W'(cnt_q >> BIT_W);
    wr_data = {bus.x_values, shift_q[WORD_W-1:1]};

    case (state_q)
      IDLE: begin
        if (rsth_ev) begin
          state_d = CAPTURE;
          cnt_d   = '0;
          shift_d = '0;
          ovf_d   = 1'b0;
          skip_d  = (SKIP_FIRST != 0);
        end
      end

      CAPTURE: begin
        if (rsth_ev) begin
          cnt_d   = '0;
          shift_d = '0;
          ovf_d   = 1'b0;
          skip_d  = (SKIP_FIRST != 0);
        end else begin
          if (get_ev) begin
            if (skip_q) begin
              skip_d = 1'b0;
            end else if (cnt_q < NUM_C) begin
              // Right shift with new bit at MSB: after WORD_W samples the
              // first sample of the word sits in the LSB.
              shift_d = wr_data;
              cnt_d   = cnt_q + 14'd1;
              wr_en   = (cnt_q[BIT_W-1:0] == LAST_BIT);
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (done_ev) begin
            if ((cnt_d == NUM_C) && !ovf_d) begin
              state_d = READY;
            end else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end
        end
      end

      READY: begin
        if (bus.Frame_Ack) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    rd_data_d = mem[bus.Rd_Addr];
  end

  // Control and status registers.
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      skip_q    <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      skip_q    <= skip_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Buffer write port; a same-Clk read of this address returns old data.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign bus.Rd_Data     = rd_data_q;
  assign bus.Frame_Valid = (state_q == READY);
  assign bus.Busy        = (state_q == CAPTURE);
  assign bus.Frame_Err   = err_q;
  assign bus.Sample_Cnt  = cnt_q;

endmodule

// File: tb/tb_ann_input_capture.sv
// ---------------------------------------------------------------------------
// tb_ann_input_capture
// Directed testbench for ann_input_capture with default parameters.
// Drives the colour-mapper strobes and the ANN handshake through the
// interface on the falling clock edge and samples outputs on the falling
// edge after the DUT's rising edge.
// ---------------------------------------------------------------------------
module tb_ann_input_capture;

  logic Clk;
  logic RST;
  int   checks;
  int   errors;

  ann_input_capture_if #(.WORD_W(16), .ADDR_W(9)) bus_if ();

  ann_input_capture #(
    .NUM_SAMPLES(8000),
    .WORD_W     (16),
    .ADDR_W     (9),
    .SKIP_FIRST (1)
  ) dut (
    .Clk(Clk),
    .RST(RST),
    .bus(bus_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Hard time limit so the run always ends.
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  // Sample value for pattern p: 0 -> k[0], 1 -> all zero, 2 -> ~k[0].
  function automatic bit pat_bit(input int k, input int p);
    bit b;
    b = k[0];
    if (p == 1) return 1'b0;
    if (p == 2) return ~b;
    return b;
  endfunction

  // One Clk of stimulus starting at a falling edge; strobes cleared after.
  task automatic drive_cycle(input bit rsth, input bit get, input bit done,
                             input bit x, input bit ack, input bit pix);
    bus_if.RstH      = rsth;
    bus_if.Get       = get;
    bus_if.Get_done  = done;
    bus_if.x_values  = x;
    bus_if.Frame_Ack = ack;
    bus_if.Pix_En    = pix;
    @(negedge Clk);
    bus_if.RstH      = 1'b0;
    bus_if.Get       = 1'b0;
    bus_if.Get_done  = 1'b0;
    bus_if.x_values  = 1'b0;
    bus_if.Frame_Ack = 1'b0;
    bus_if.Pix_En    = 1'b0;
  endtask

  // RstH, lead-in Get, n samples, Get_done (optionally merged with last Get).
  task automatic run_frame(input int n, input int pattern, input bit merge_done);
    drive_cycle(1, 0, 0, 0, 0, 1);
    drive_cycle(0, 1, 0, 0, 0, 1);
    for (int k = 0; k < n; k++) begin
      if (merge_done && (k == n - 1))
        drive_cycle(0, 1, 1, pat_bit(k, pattern), 0, 1);
      else
        drive_cycle(0, 1, 0, pat_bit(k, pattern), 0, 1);
    end
    if (!merge_done) drive_cycle(0, 0, 1, 0, 0, 1);
  endtask

  task automatic read_word(input int addr, output logic [15:0] data);
    bus_if.Rd_Addr = 9'(addr);
    @(negedge Clk);
    data = bus_if.Rd_Data;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if (bus_if.Frame_Valid !== 1'b0 || bus_if.Frame_Err !== 1'b0 || bus_if.Busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got valid=%b err=%b busy=%b expected 0 0 0",
               bus_if.Frame_Valid, bus_if.Frame_Err, bus_if.Busy);
    end
    checks++;
    if (bus_if.Sample_Cnt !== 14'd0) begin
      errors++;
      $display("[TB] FAIL reset_cnt: got %0d expected 0", bus_if.Sample_Cnt);
    end
    checks++;
    if (bus_if.Rd_Data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_rd_data: got %h expected 0000", bus_if.Rd_Data);
    end
    RST = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_full_frame;
    logic [15:0] d;
    int bad;
    run_frame(8000, 0, 0);
    checks++;
    if (bus_if.Frame_Valid !== 1'b1 || bus_if.Frame_Err !== 1'b0 || bus_if.Busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_status: got valid=%b err=%b busy=%b expected 1 0 0",
               bus_if.Frame_Valid, bus_if.Frame_Err, bus_if.Busy);
    end
    checks++;
    if (bus_if.Sample_Cnt !== 14'd8000) begin
      errors++;
      $display("[TB] FAIL full_cnt: got %0d expected 8000", bus_if.Sample_Cnt);
    end
    bad = 0;
    for (int a = 0; a < 500; a++) begin
      read_word(a, d);
      checks++;
      if (d !== 16'hAAAA) begin
        errors++;
        if (bad < 8) $display("[TB] FAIL full_word[%0d]: got %h expected aaaa", a, d);
        bad++;
      end
    end
    drive_cycle(0, 0, 0, 0, 1, 1);
    checks++;
    if (bus_if.Frame_Valid !== 1'b0 || bus_if.Busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_ack: got valid=%b busy=%b expected 0 0",
               bus_if.Frame_Valid, bus_if.Busy);
    end
    checks++;
    if (bus_if.Sample_Cnt !== 14'd8000) begin
      errors++;
      $display("[TB] FAIL full_cnt_hold: got %0d expected 8000", bus_if.Sample_Cnt);
    end
  endtask

  task automatic test_short_frame;
    run_frame(7999, 0, 0);
    checks++;
    if (bus_if.Frame_Err !== 1'b1 || bus_if.Frame_Valid !== 1'b0 || bus_if.Busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL short_status: got err=%b valid=%b busy=%b expected 1 0 0",
               bus_if.Frame_Err, bus_if.Frame_Valid, bus_if.Busy);
    end
    checks++;
    if (bus_if.Sample_Cnt !== 14'd7999) begin
      errors++;
      $display("[TB] FAIL short_cnt: got %0d expected 7999", bus_if.Sample_Cnt);
    end
    drive_cycle(0, 0, 0, 0, 0, 1);
    checks++;
    if (bus_if.Frame_Err !== 1'b0 || bus_if.Frame_Valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL short_pulse: got err=%b valid=%b expected 0 0",
               bus_if.Frame_Err, bus_if.Frame_Valid);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] d;
    run_frame(8001, 2, 0);
    checks++;
    if (bus_if.Frame_Err !== 1'b1 || bus_if.Frame_Valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_status: got err=%b valid=%b expected 1 0",
               bus_if.Frame_Err, bus_if.Frame_Valid);
    end
    checks++;
    if (bus_if.Sample_Cnt !== 14'd8000) begin
      errors++;
      $display("[TB] FAIL ovf_cnt: got %0d expected 8000", bus_if.Sample_Cnt);
    end
    drive_cycle(0, 0, 0, 0, 0, 1);
    checks++;
    if (bus_if.Frame_Err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_pulse: got err=%b expected 0", bus_if.Frame_Err);
    end
    read_word(499, d);
    checks++;
    if (d !== 16'h5555) begin
      errors++;
      $display("[TB] FAIL ovf_word499: got %h expected 5555", d);
    end
    read_word(0, d);
    checks++;
    if (d !== 16'h5555) begin
      errors++;
      $display("[TB] FAIL ovf_word0: got %h expected 5555", d);
    end
  endtask

  task automatic test_held_buffer;
    logic [15:0] d;
    int addrs [3];
    int bad;
    addrs = '{0, 123, 499};
    run_frame(8000, 0, 0);
    checks++;
    if (bus_if.Frame_Valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL held_first_valid: got %b expected 1", bus_if.Frame_Valid);
    end
    run_frame(8000, 1, 0);
    checks++;
    if (bus_if.Frame_Valid !== 1'b1 || bus_if.Busy !== 1'b0 || bus_if.Frame_Err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL held_ignored: got valid=%b busy=%b err=%b expected 1 0 0",
               bus_if.Frame_Valid, bus_if.Busy, bus_if.Frame_Err);
    end
    checks++;
    if (bus_if.Sample_Cnt !== 14'd8000) begin
      errors++;
      $display("[TB] FAIL held_cnt: got %0d expected 8000", bus_if.Sample_Cnt);
    end
    foreach (addrs[i]) begin
      read_word(addrs[i], d);
      checks++;
      if (d !== 16'hAAAA) begin
        errors++;
        $display("[TB] FAIL held_word[%0d]: got %h expected aaaa", addrs[i], d);
      end
    end
    // Ack together with a RstH event: the RstH must not start a capture.
    drive_cycle(1, 0, 0, 0, 1, 1);
    checks++;
    if (bus_if.Frame_Valid !== 1'b0 || bus_if.Busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL held_ack_rsth: got valid=%b busy=%b expected 0 0",
               bus_if.Frame_Valid, bus_if.Busy);
    end
    run_frame(8000, 1, 0);
    checks++;
    if (bus_if.Frame_Valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL held_zero_valid: got %b expected 1", bus_if.Frame_Valid);
    end
    bad = 0;
    for (int a = 0; a < 500; a++) begin
      read_word(a, d);
      checks++;
      if (d !== 16'h0000) begin
        errors++;
        if (bad < 8) $display("[TB] FAIL held_zero_word[%0d]: got %h expected 0000", a, d);
        bad++;
      end
    end
    drive_cycle(0, 0, 0, 0, 1, 1);
  endtask

  task automatic test_mid_frame_rsth;
    logic [15:0] d;
    drive_cycle(1, 0, 0, 0, 0, 1);
    drive_cycle(0, 1, 0, 0, 0, 1);
    for (int k = 0; k < 3000; k++) drive_cycle(0, 1, 0, pat_bit(k, 0), 0, 1);
    checks++;
    if (bus_if.Busy !== 1'b1 || bus_if.Sample_Cnt !== 14'd3000) begin
      errors++;
      $display("[TB] FAIL mid_partial: got busy=%b cnt=%0d expected 1 3000",
               bus_if.Busy, bus_if.Sample_Cnt);
    end
    // Restart, with the final Get and Get_done in the same Clk.
    run_frame(8000, 0, 1);
    checks++;
    if (bus_if.Frame_Valid !== 1'b1 || bus_if.Frame_Err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_status: got valid=%b err=%b expected 1 0",
               bus_if.Frame_Valid, bus_if.Frame_Err);
    end
    checks++;
    if (bus_if.Sample_Cnt !== 14'd8000) begin
      errors++;
      $display("[TB] FAIL mid_cnt: got %0d expected 8000", bus_if.Sample_Cnt);
    end
    read_word(499, d);
    checks++;
    if (d !== 16'hAAAA) begin
      errors++;
      $display("[TB] FAIL mid_word499: got %h expected aaaa", d);
    end
    read_word(300, d);
    checks++;
    if (d !== 16'hAAAA) begin
      errors++;
      $display("[TB] FAIL mid_word300: got %h expected aaaa", d);
    end
    drive_cycle(0, 0, 0, 0, 1, 1);
  endtask

  task automatic test_pix_en_gating;
    drive_cycle(1, 0, 0, 0, 0, 1);
    drive_cycle(0, 1, 0, 0, 0, 1);
    checks++;
    if (bus_if.Sample_Cnt !== 14'd0 || bus_if.Busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL gate_leadin: got cnt=%0d busy=%b expected 0 1",
               bus_if.Sample_Cnt, bus_if.Busy);
    end
    drive_cycle(0, 1, 0, 1, 0, 1);
    drive_cycle(0, 1, 0, 1, 0, 0);
    checks++;
    if (bus_if.Sample_Cnt !== 14'd1) begin
      errors++;
      $display("[TB] FAIL gate_count: got %0d expected 1", bus_if.Sample_Cnt);
    end
    // Asynchronous reset between clock edges.
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if (bus_if.Busy !== 1'b0 || bus_if.Sample_Cnt !== 14'd0 || bus_if.Frame_Valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got busy=%b cnt=%0d valid=%b expected 0 0 0",
               bus_if.Busy, bus_if.Sample_Cnt, bus_if.Frame_Valid);
    end
    @(negedge Clk);
    RST = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    RST              = 1'b0;
    bus_if.Pix_En    = 1'b0;
    bus_if.RstH      = 1'b0;
    bus_if.Get       = 1'b0;
    bus_if.Get_done  = 1'b0;
    bus_if.x_values  = 1'b0;
    bus_if.Frame_Ack = 1'b0;
    bus_if.Rd_Addr   = '0;

    test_reset();
    test_full_frame();
    test_short_frame();
    test_overflow();
    test_held_buffer();
    test_mid_frame_rsth();
    test_pix_en_gating();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
